// File: rtl/wb_pkg.sv
// Shared widths and the queued-write record for the register-file write arbiter.
package wb_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] val;
  } wb_req_t;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_PIPE = 2'd1,
    SEL_FIFO = 2'd2
  } wr_sel_e;

  function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of queued long-latency writes with a live bit per entry,
// kill-by-dest, and per-entry source compares. WB_FWD_EN adds youngest-match data outputs.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [REG_AW-1:0]             push_dest,
  input  logic [DATA_W-1:0]             push_val,
  input  logic                          pop,
  input  logic                          kill_en,
  input  logic [REG_AW-1:0]             kill_dest,
  input  logic [REG_AW-1:0]             src1,
  input  logic [REG_AW-1:0]             src2,
  output logic [REG_AW-1:0]             head_dest,
  output logic [DATA_W-1:0]             head_val,
  output logic                          head_live,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DEPTH-1:0]              hit1,
  output logic [DEPTH-1:0]              hit2
`ifdef WB_FWD_EN
  ,
  output logic [DATA_W-1:0]             fwd1_val,
  output logic [DATA_W-1:0]             fwd2_val
`endif
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t          mem [DEPTH];
  logic [DEPTH-1:0] live;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{dest: push_dest, val: push_val};
    end
  end

  // Kill is applied first so an entry pushed in the same cycle stays live.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      live   <= '0;
    end else begin
      if (kill_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem[i].dest == kill_dest) live[i] <= 1'b0;
        end
      end
      if (pop) begin
        live[rd_ptr] <= 1'b0;
        rd_ptr       <= rd_ptr + 1'b1;
      end
      if (push) begin
        live[wr_ptr] <= 1'b1;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_dest = mem[rd_ptr].dest;
  assign head_val  = mem[rd_ptr].val;
  assign head_live = live[rd_ptr];

  // Slots outside the occupied range always have live=0, so no range check is needed.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = live[i] && reg_match(src1, mem[i].dest);
      hit2[i] = live[i] && reg_match(src2, mem[i].dest);
    end
  end

`ifdef WB_FWD_EN
  // Walk oldest to youngest; the last hit wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd1_val = '0;
    fwd2_val = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (hit1[idx]) fwd1_val = mem[idx].val;
      if (hit2[idx]) fwd2_val = mem[idx].val;
    end
  end
`endif

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges WB-stage writes with queued long-latency results onto the single register-file
// write port. Optional forwarding outputs are enabled by defining WB_FWD_EN.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pipe_we,
  input  logic [4:0]         pipe_dest,
  input  logic [31:0]        pipe_val,
  input  logic               lu_valid,
  input  logic [4:0]         lu_dest,
  input  logic [31:0]        lu_val,
  output logic               lu_ready,
  input  logic [4:0]         rd_src1,
  input  logic [4:0]         rd_src2,
  output logic               hazard,
  output logic               stall_req,
  output logic               wr_en,
  output logic [4:0]         wr_dest,
  output logic [31:0]        wr_val
`ifdef WB_FWD_EN
  ,
  output logic               fwd1_hit,
  output logic [31:0]        fwd1_val,
  output logic               fwd2_hit,
  output logic [31:0]        fwd2_val
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]       count;
  logic [REG_AW-1:0]   head_dest;
  logic [DATA_W-1:0]   head_val;
  logic                head_live;
  logic [DEPTH-1:0]    hit1;
  logic [DEPTH-1:0]    hit2;
  logic [SW-1:0]       starve_cnt;
  logic                wb_hit;
  logic                push;
  logic                pop;
  wr_sel_e             wr_sel;

  // lu handshake: a transfer happens on a posedge where lu_valid && lu_ready; the
  // producer holds lu_dest/lu_val stable until then. lu_ready depends on registered
  // count only. Dest-0 transfers complete but are discarded.
  assign lu_ready = (count < CW'(DEPTH));
  assign push     = lu_valid && lu_ready && (lu_dest != '0);
  assign wb_hit   = pipe_we && (pipe_dest != '0);
  assign pop      = (wr_sel == SEL_FIFO);

  always_comb begin
    wr_sel = SEL_NONE;
    if (wb_hit)             wr_sel = SEL_PIPE;
    else if (count != '0)   wr_sel = SEL_FIFO;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_dest (lu_dest),
    .push_val  (lu_val),
    .pop       (pop),
    .kill_en   (wb_hit),
    .kill_dest (pipe_dest),
    .src1      (rd_src1),
    .src2      (rd_src2),
    .head_dest (head_dest),
    .head_val  (head_val),
    .head_live (head_live),
    .count     (count),
    .hit1      (hit1),
    .hit2      (hit2)
`ifdef WB_FWD_EN
    ,
    .fwd1_val  (fwd1_val),
    .fwd2_val  (fwd2_val)
`endif
  );

  assign hazard    = (|hit1) || (|hit2);
  assign stall_req = (starve_cnt == SW'(STARVE_LIMIT));

`ifdef WB_FWD_EN
  assign fwd1_hit = |hit1;
  assign fwd2_hit = |hit2;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_dest <= '0;
      wr_val  <= '0;
    end else begin
      case (wr_sel)
        SEL_PIPE: begin
          wr_en   <= 1'b1;
          wr_dest <= pipe_dest;
          wr_val  <= pipe_val;
        end
        SEL_FIFO: begin
          wr_en   <= head_live;
          wr_dest <= head_dest;
          wr_val  <= head_val;
        end
        default: wr_en <= 1'b0;
      endcase
    end
  end

  // Counts only cycles where WB preempts a non-empty queue; any pop or empty queue clears.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (wb_hit && (count != '0)) begin
      if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: vector table plus hand-written fill, starve and forwarding sequences.
module tb_wb_write_arbiter;

  localparam int W = 37;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_dest = '0;
  logic [31:0] pipe_val = '0;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_dest = '0;
  logic [31:0] lu_val = '0;
  logic        lu_ready;
  logic [4:0]  rd_src1 = '0;
  logic [4:0]  rd_src2 = '0;
  logic        hazard;
  logic        stall_req;
  logic        wr_en;
  logic [4:0]  wr_dest;
  logic [31:0] wr_val;
`ifdef WB_FWD_EN
  logic        fwd1_hit;
  logic [31:0] fwd1_val;
  logic        fwd2_hit;
  logic [31:0] fwd2_val;
`endif

  wb_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_dest (pipe_dest),
    .pipe_val  (pipe_val),
    .lu_valid  (lu_valid),
    .lu_dest   (lu_dest),
    .lu_val    (lu_val),
    .lu_ready  (lu_ready),
    .rd_src1   (rd_src1),
    .rd_src2   (rd_src2),
    .hazard    (hazard),
    .stall_req (stall_req),
    .wr_en     (wr_en),
    .wr_dest   (wr_dest),
    .wr_val    (wr_val)
`ifdef WB_FWD_EN
    ,
    .fwd1_hit  (fwd1_hit),
    .fwd1_val  (fwd1_val),
    .fwd2_hit  (fwd2_hit),
    .fwd2_val  (fwd2_val)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pw;
    logic [4:0]  pd;
    logic [31:0] pv;
    logic        lv;
    logic [4:0]  ld;
    logic [31:0] lval;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        e_ready;
    logic        e_haz;
    logic        e_stall;
    logic        e_en;
    logic [4:0]  e_dest;
    logic [31:0] e_val;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;
  vec_t vecs[$];
  logic [W-1:0] exp_q[$];

  function automatic vec_t mk(logic r, logic pw, logic [4:0] pd, logic [31:0] pv,
                              logic lv, logic [4:0] ld, logic [31:0] lval,
                              logic [4:0] s1, logic [4:0] s2,
                              logic er, logic eh, logic es,
                              logic ee, logic [4:0] ed, logic [31:0] ev);
    vec_t v;
    v.rst = r;  v.pw = pw; v.pd = pd; v.pv = pv;
    v.lv = lv;  v.ld = ld; v.lval = lval; v.s1 = s1; v.s2 = s2;
    v.e_ready = er; v.e_haz = eh; v.e_stall = es;
    v.e_en = ee; v.e_dest = ed; v.e_val = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // driver: inputs change at negedge; combinational outputs checked 1ns later
  task automatic drive_pre(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst; pipe_we = v.pw; pipe_dest = v.pd; pipe_val = v.pv;
    lu_valid = v.lv; lu_dest = v.ld; lu_val = v.lval;
    rd_src1 = v.s1; rd_src2 = v.s2;
    #1;
    chk({tag, ".lu_ready"},  64'(lu_ready),  64'(v.e_ready));
    chk({tag, ".hazard"},    64'(hazard),    64'(v.e_haz));
    chk({tag, ".stall_req"}, 64'(stall_req), 64'(v.e_stall));
  endtask

  task automatic finish_post(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    chk({tag, ".wr_en"},   64'(wr_en),   64'(v.e_en));
    chk({tag, ".wr_dest"}, 64'(wr_dest), 64'(v.e_dest));
    chk({tag, ".wr_val"},  64'(wr_val),  64'(v.e_val));
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive_pre(v, tag);
    finish_post(v, tag);
  endtask

  // scoreboard: idle cycle, compare the popped write against the expected queue
  task automatic drain_one(input string tag);
    logic [W-1:0] e;
    @(negedge clk);
    rst = 1'b1; pipe_we = 1'b0; lu_valid = 1'b0;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s.exp_q: scoreboard empty on drain", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".wr_en"},  64'(wr_en), 64'(1));
      chk({tag, ".wr_req"}, 64'({wr_dest, wr_val}), 64'(e));
    end
  endtask

  initial begin
    // two reset cycles before the table also hold rst low
    repeat (2) @(posedge clk);

    // reset with lu_valid held, then release
    vecs.push_back(mk(0,0,0,0, 1,4,32'h99, 0,0,  1,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,4,32'h99, 0,0,  1,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0,0,      4,0,  1,0,0, 0,0,0));
    // WB priority over a queued r5
    vecs.push_back(mk(1,0,0,0,        1,5,32'h11, 5,0, 1,0,0, 0,0,0));
    vecs.push_back(mk(1,1,7,32'h22,   0,0,0,      5,0, 1,1,0, 1,7,32'h22));
    vecs.push_back(mk(1,1,7,32'h22,   0,0,0,      5,0, 1,1,0, 1,7,32'h22));
    vecs.push_back(mk(1,1,7,32'h22,   0,0,0,      5,0, 1,1,0, 1,7,32'h22));
    vecs.push_back(mk(1,0,0,0,        0,0,0,      5,0, 1,1,0, 1,5,32'h11));
    vecs.push_back(mk(1,0,0,0,        0,0,0,      5,0, 1,0,0, 0,5,32'h11));
    // WAW kill of queued r9, then same-cycle push survives the kill
    vecs.push_back(mk(1,0,0,0,        1,9,32'hA,  9,0, 1,0,0, 0,5,32'h11));
    vecs.push_back(mk(1,1,9,32'hB,    0,0,0,      9,0, 1,1,0, 1,9,32'hB));
    vecs.push_back(mk(1,0,0,0,        0,0,0,      9,0, 1,0,0, 0,9,32'hA));
    vecs.push_back(mk(1,0,0,0,        0,0,0,      9,0, 1,0,0, 0,9,32'hA));
    vecs.push_back(mk(1,1,9,32'hC,    1,9,32'hD,  0,9, 1,0,0, 1,9,32'hC));
    vecs.push_back(mk(1,0,0,0,        0,0,0,      0,9, 1,1,0, 1,9,32'hD));
    vecs.push_back(mk(1,0,0,0,        0,0,0,      0,9, 1,0,0, 0,9,32'hD));
    // r0 writes from both sources are dropped
    vecs.push_back(mk(1,1,0,32'h1,    1,0,32'hFF, 0,0, 1,0,0, 0,9,32'hD));
    vecs.push_back(mk(1,0,0,0,        0,0,0,      0,0, 1,0,0, 0,9,32'hD));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // fill: WB holds the port so nothing pops; 5th lu_valid is refused
    for (int i = 0; i < 5; i++) begin
      logic rdy;
      rdy = (i < 4);
      if (i < 4) exp_q.push_back({5'(10 + i), 32'(32'h100 + i)});
      apply(mk(1,1,1,32'(32'h1001 + i), 1,(i < 4) ? 5'(10 + i) : 5'd20,
               (i < 4) ? 32'(32'h100 + i) : 32'h200,
               12,0, rdy,(i == 3 || i == 4),0, 1,1,32'(32'h1001 + i)),
            $sformatf("fill%0d", i));
    end
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    apply(mk(1,0,0,0, 1,20,32'h200, 12,0, 0,1,0, 1,10,32'h100), "fill_pop");
    apply(mk(1,0,0,0, 1,20,32'h200, 12,0, 1,1,0, 1,11,32'h101), "fill_pushpop");
    exp_q.push_back({5'd20, 32'h200});
    apply(mk(1,1,1,32'h1006, 1,21,32'h201, 12,0, 1,1,0, 1,1,32'h1006), "fill_refill");
    exp_q.push_back({5'd21, 32'h201});
    apply(mk(1,1,1,32'h1007, 0,0,0, 12,0, 0,1,0, 1,1,32'h1007), "fill_full");
    for (int i = 0; i < 4; i++) drain_one($sformatf("drain%0d", i));
    apply(mk(1,0,0,0, 0,0,0, 12,0, 1,0,0, 0,21,32'h201), "fill_empty");

    // starvation: one queued r6 while WB writes every cycle
    apply(mk(1,1,2,32'h2000, 1,6,32'h66, 6,0, 1,0,0, 1,2,32'h2000), "starve_q");
    for (int k = 1; k <= 9; k++) begin
      apply(mk(1,1,2,32'(32'h2000 + k), 0,0,0, 6,0, 1,1,(k == 9), 1,2,32'(32'h2000 + k)),
            $sformatf("starve%0d", k));
    end
    apply(mk(1,0,0,0, 0,0,0, 6,0, 1,1,1, 1,6,32'h66), "starve_drain");
    apply(mk(1,0,0,0, 0,0,0, 6,0, 1,0,0, 0,6,32'h66), "starve_clear");

`ifdef WB_FWD_EN
    // forwarding returns the youngest live match
    begin
      vec_t v;
      v = mk(1,1,1,32'h3001, 1,3,32'h5, 3,3, 1,0,0, 1,1,32'h3001);
      drive_pre(v, "fwd0");
      chk("fwd0.fwd1_hit", 64'(fwd1_hit), 64'(0));
      finish_post(v, "fwd0");
      v = mk(1,1,1,32'h3002, 1,3,32'h6, 3,3, 1,1,0, 1,1,32'h3002);
      drive_pre(v, "fwd1");
      chk("fwd1.fwd1_val", 64'(fwd1_val), 64'(32'h5));
      finish_post(v, "fwd1");
      v = mk(1,1,1,32'h3003, 0,0,0, 3,3, 1,1,0, 1,1,32'h3003);
      drive_pre(v, "fwd2");
      chk("fwd2.fwd1_hit", 64'(fwd1_hit), 64'(1));
      chk("fwd2.fwd1_val", 64'(fwd1_val), 64'(32'h6));
      chk("fwd2.fwd2_val", 64'(fwd2_val), 64'(32'h6));
      finish_post(v, "fwd2");
      exp_q.push_back({5'd3, 32'h5});
      exp_q.push_back({5'd3, 32'h6});
      drain_one("fwd_drain0");
      drain_one("fwd_drain1");
    end
`endif

    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL exp_q_left: got %0d entries expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
